counter_run_sequencer: RTL and testbench

- Shares one up/down WIDTH-bit counter datapath between NREQ requesters.
- Each requester asks for a "count run": a start value, a direction and a step count (len).
- The block arbitrates round-robin, loads the counter, steps it len times, then signals completion.
- It sits between control agents (e.g. test-pattern or timing generators) and the shared counter output q.

---
 rtl/counter_run_pkg.sv | 14 +
 rtl/updown_core.sv | 46 ++++
 rtl/counter_run_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_counter_run_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_run_pkg.sv
// Shared types for the counter run sequencer: FSM state encoding and direction constants.
package counter_run_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/updown_core.sv
// Modulo-2^WIDTH up/down counter register with parallel load; load wins over step.
module updown_core
  import counter_run_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  input  logic             dir,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // next counter value: load, step in the requested direction, or hold
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (step) begin
      if (dir == DIR_DOWN) begin
        q_d = q_q - WIDTH'(1);
      end else begin
        q_d = q_q + WIDTH'(1);
      end
    end else begin
      q_d = q_q;
    end
  end

  // counter register
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q_q <= {WIDTH{1'b0}};
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/counter_run_sequencer.sv
// Round-robin arbitration of NREQ requesters onto one shared up/down counter run.
// Optional pause input in RUN when COUNTER_RUN_SEQ_PAUSE_EN is defined.
module counter_run_sequencer
  import counter_run_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = 4,
  parameter int LEN_W = 4
) (
`ifdef COUNTER_RUN_SEQ_PAUSE_EN
  input  logic                      pause,
`endif
  input  logic                      clk,
  input  logic                      clr_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           dir,
  input  logic [NREQ*WIDTH-1:0]     start_val,
  input  logic [NREQ*LEN_W-1:0]     len,
  output logic [NREQ-1:0]           gnt,
  output logic                      busy,
  output logic [WIDTH-1:0]          q,
  output logic                      dir_out,
  output logic                      done,
  output logic [$clog2(NREQ)-1:0]   done_id
);

  localparam int IDW = $clog2(NREQ);

  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [IDW-1:0]    done_id_q, done_id_d;
  logic              dir_out_q, dir_out_d;
  logic [IDW-1:0]    rr_q, rr_d;
  logic [IDW-1:0]    win_q, win_d;
  logic [LEN_W-1:0]  rem_q, rem_d;

  logic              any_req_s;
  logic [IDW-1:0]    pick_s;
  logic              load_s;
  logic              step_s;
  logic              pause_s;
  logic [WIDTH-1:0]  load_val_s;

`ifdef COUNTER_RUN_SEQ_PAUSE_EN
  assign pause_s = pause;
`else
  assign pause_s = 1'b0;
`endif

  // round-robin pick: scan downward so the lowest offset from rr_q is assigned last and wins
  always_comb begin
    int idx;
    idx       = 0;
    pick_s    = rr_q;
    any_req_s = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(rr_q) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end else begin
        idx = idx;
      end
      if (req[idx]) begin
        pick_s    = IDW'(idx);
        any_req_s = 1'b1;
      end else begin
        any_req_s = any_req_s;
      end
    end
  end

  assign load_val_s = start_val[pick_s*WIDTH +: WIDTH];

  // run sequencing: next state and registered-output next values
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    dir_out_d = dir_out_q;
    rr_d      = rr_q;
    win_d     = win_q;
    rem_d     = rem_q;
    load_s    = 1'b0;
    step_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req_s) begin
          state_d   = LOAD;
          gnt_d     = {{(NREQ-1){1'b0}}, 1'b1} << pick_s;
          busy_d    = 1'b1;
          win_d     = pick_s;
          dir_out_d = dir[pick_s];
          rem_d     = len[pick_s*LEN_W +: LEN_W];
          load_s    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (rem_q == {LEN_W{1'b0}}) begin
          state_d   = DONE;
          done_d    = 1'b1;
          done_id_d = win_q;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (pause_s) begin
          state_d = RUN;
        end else begin
          step_s = 1'b1;
          rem_d  = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d   = DONE;
            done_d    = 1'b1;
            done_id_d = win_q;
          end else begin
            state_d = RUN;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = {NREQ{1'b0}};
        busy_d  = 1'b0;
        rr_d    = (win_q == IDW'(NREQ - 1)) ? {IDW{1'b0}} : win_q + IDW'(1);
      end
      default: begin
        state_d = IDLE;
        gnt_d   = {NREQ{1'b0}};
        busy_d  = 1'b0;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= IDLE;
      gnt_q     <= {NREQ{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= {IDW{1'b0}};
      dir_out_q <= DIR_UP;
      rr_q      <= {IDW{1'b0}};
      win_q     <= {IDW{1'b0}};
      rem_q     <= {LEN_W{1'b0}};
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
      dir_out_q <= dir_out_d;
      rr_q      <= rr_d;
      win_q     <= win_d;
      rem_q     <= rem_d;
    end
  end

  updown_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .clr_n    (clr_n),
    .load     (load_s),
    .load_val (load_val_s),
    .step     (step_s),
    .dir      (dir_out_q),
    .q        (q)
  );

  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign done_id = done_id_q;
  assign dir_out = dir_out_q;

endmodule

// File: tb/tb_counter_run_sequencer.sv
// Directed, table-driven bench for counter_run_sequencer (NREQ=2, WIDTH=4, LEN_W=4).
// Define COUNTER_RUN_SEQ_PAUSE_EN to also exercise the pause input.
module tb_counter_run_sequencer;

  localparam int NREQ  = 2;
  localparam int WIDTH = 4;
  localparam int LEN_W = 4;

  logic       clk = 1'b0;
  logic       clr_n;
  logic [1:0] req;
  logic [1:0] dir;
  logic [7:0] start_val;
  logic [7:0] len;
  logic [1:0] gnt;
  logic       busy;
  logic [3:0] q;
  logic       dir_out;
  logic       done;
  logic [0:0] done_id;
`ifdef COUNTER_RUN_SEQ_PAUSE_EN
  logic       pause;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  counter_run_sequencer #(.NREQ(NREQ), .WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
`ifdef COUNTER_RUN_SEQ_PAUSE_EN
    .pause     (pause),
`endif
    .clk       (clk),
    .clr_n     (clr_n),
    .req       (req),
    .dir       (dir),
    .start_val (start_val),
    .len       (len),
    .gnt       (gnt),
    .busy      (busy),
    .q         (q),
    .dir_out   (dir_out),
    .done      (done),
    .done_id   (done_id)
  );

  typedef struct {
    logic [1:0] req;
    logic [1:0] dir;
    logic [7:0] sv;
    logic [7:0] ln;
    int         exp_id;
    logic [3:0] exp_q;
    logic       exp_dir;
    int         exp_cyc;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int n, input vec_t v);
    int gcyc, bcyc, dcnt, dcyc, multi;
    logic [3:0] dq;
    logic [0:0] did;
    logic       ddir;
    logic [1:0] dg;
    gcyc = 0; bcyc = 0; dcnt = 0; dcyc = -1; multi = 0;
    dq = 4'h0; did = 1'b0; ddir = 1'b0; dg = 2'b00;
    req = v.req; dir = v.dir; start_val = v.sv; len = v.ln;
    tick();
    req = 2'b00; dir = ~v.dir; start_val = ~v.sv; len = 8'h11;
    for (int c = 1; c <= 40; c++) begin
      if (gnt != 2'b00) gcyc++;
      if (busy) bcyc++;
      if (gnt == 2'b11) multi++;
      if (done) begin
        dcnt++; dcyc = c; dq = q; did = done_id; ddir = dir_out; dg = gnt;
      end
      if (!busy && gnt == 2'b00) break;
      tick();
    end
    check($sformatf("v%0d_idle_reached", n), busy, 1'b0);
    check($sformatf("v%0d_done_count", n), dcnt, 1);
    check($sformatf("v%0d_done_cycle", n), dcyc, v.exp_cyc);
    check($sformatf("v%0d_done_id", n), did, v.exp_id);
    check($sformatf("v%0d_q_at_done", n), dq, v.exp_q);
    check($sformatf("v%0d_dir_out", n), ddir, v.exp_dir);
    check($sformatf("v%0d_gnt_at_done", n), dg, v.req);
    check($sformatf("v%0d_gnt_cycles", n), gcyc, v.exp_cyc);
    check($sformatf("v%0d_busy_cycles", n), bcyc, v.exp_cyc);
    check($sformatf("v%0d_onehot", n), multi, 0);
    check($sformatf("v%0d_q_hold_idle", n), q, v.exp_q);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] t1_q[6];
    logic [1:0] t1_g[6];
    logic       t1_d[6];
    logic [1:0] rr_exp[4];
    logic [1:0] rr_got[4];
    logic [1:0] prev;
    int         ngr, multi, seen_done;

    vecs[0] = '{2'b10, 2'b10, 8'h10, 8'h20, 1, 4'hF, 1'b1, 4};
    vecs[1] = '{2'b01, 2'b00, 8'h07, 8'h00, 0, 4'h7, 1'b0, 2};
    vecs[2] = '{2'b10, 2'b00, 8'h30, 8'h50, 1, 4'h8, 1'b0, 7};
    vecs[3] = '{2'b01, 2'b01, 8'h00, 8'h0F, 0, 4'h1, 1'b1, 17};
    vecs[4] = '{2'b10, 2'b00, 8'h90, 8'hF0, 1, 4'h8, 1'b0, 17};
    vecs[5] = '{2'b01, 2'b01, 8'h0C, 8'h05, 0, 4'h7, 1'b1, 7};

    t1_q = '{4'hE, 4'hE, 4'hF, 4'h0, 4'h1, 4'h1};
    t1_g = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
    t1_d = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    rr_exp = '{2'b01, 2'b10, 2'b01, 2'b10};

    clr_n = 1'b0; req = 2'b00; dir = 2'b00; start_val = 8'h00; len = 8'h00;
`ifdef COUNTER_RUN_SEQ_PAUSE_EN
    pause = 1'b0;
`endif
    #12;
    check("rst_q", q, 4'h0);
    check("rst_gnt", gnt, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_done_id", done_id, 1'b0);
    check("rst_dir_out", dir_out, 1'b0);
    @(negedge clk);
    clr_n = 1'b1;
    tick();

    // up-run with wrap, cycle by cycle from LOAD
    req = 2'b01; dir = 2'b00; start_val = 8'h0E; len = 8'h03;
    tick();
    req = 2'b00;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t1_q_c%0d", i), q, t1_q[i]);
      check($sformatf("t1_gnt_c%0d", i), gnt, t1_g[i]);
      check($sformatf("t1_done_c%0d", i), done, t1_d[i]);
      if (t1_d[i]) check("t1_done_id", done_id, 1'b0);
      tick();
    end

    for (int n = 0; n < 6; n++) run_vec(n, vecs[n]);

    // reset mid-run: abort after three steps
    req = 2'b01; dir = 2'b00; start_val = 8'h00; len = 8'h08;
    tick();
    req = 2'b00;
    for (int i = 0; i < 4; i++) tick();
    check("t5_q_before_rst", q, 4'h3);
    check("t5_busy_before_rst", busy, 1'b1);
    #3;
    clr_n = 1'b0;
    #1;
    check("t5_q_rst", q, 4'h0);
    check("t5_gnt_rst", gnt, 2'b00);
    check("t5_busy_rst", busy, 1'b0);
    @(negedge clk);
    clr_n = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done || busy) seen_done++;
    end
    check("t5_no_done_after_rst", seen_done, 0);

    // round-robin with both requesters held; rr pointer restarts at 0
    req = 2'b11; dir = 2'b00; start_val = 8'h00; len = 8'h11;
    ngr = 0; multi = 0; prev = 2'b00;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (gnt == 2'b11) multi++;
      if (gnt != 2'b00 && prev != 2'b00 && gnt != prev) multi++;
      if (gnt != 2'b00 && prev == 2'b00) begin
        rr_got[ngr] = gnt;
        ngr++;
      end
      prev = gnt;
      if (ngr == 4) break;
    end
    req = 2'b00;
    check("t3_grant_count", ngr, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < ngr) check($sformatf("t3_grant_%0d", i), rr_got[i], rr_exp[i]);
    end
    check("t3_onehot_and_gaps", multi, 0);
    for (int c = 0; c < 10; c++) begin
      if (!busy) break;
      tick();
    end
    check("t3_idle_reached", busy, 1'b0);

`ifdef COUNTER_RUN_SEQ_PAUSE_EN
    // pause for two RUN cycles after the second step
    req = 2'b01; dir = 2'b00; start_val = 8'h00; len = 8'h04;
    tick();
    req = 2'b00;
    tick();
    tick();
    tick();
    check("t6_q_before_pause", q, 4'h2);
    pause = 1'b1;
    tick();
    check("t6_q_pause1", q, 4'h2);
    tick();
    check("t6_q_pause2", q, 4'h2);
    pause = 1'b0;
    tick();
    check("t6_q_after_pause", q, 4'h3);
    check("t6_no_early_done", done, 1'b0);
    tick();
    check("t6_final_q", q, 4'h4);
    check("t6_done_late", done, 1'b1);
    tick();
    check("t6_idle", busy, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
